// File: rtl/fle_lut_cfg_stage_if.sv
// LUT stage bus: serial configuration chain, LUT select/result and status flags.
// The master side (fabric or testbench) drives configuration and select inputs.
// The slave side is the LUT stage itself.
interface fle_lut_cfg_stage_if #(
  parameter int K = 4
);
  logic         cfg_en;
  logic         ccff_head;
  logic         ccff_tail;
  logic [K-1:0] lut_in;
  logic         lut_out;
  logic         cfg_done;
  logic         cfg_err;

  modport master (
    output cfg_en,
    output ccff_head,
    output lut_in,
    input  ccff_tail,
    input  lut_out,
    input  cfg_done,
    input  cfg_err
  );

  modport slave (
    input  cfg_en,
    input  ccff_head,
    input  lut_in,
    output ccff_tail,
    output lut_out,
    output cfg_done,
    output cfg_err
  );
endinterface

// File: rtl/fle_lut_cfg_stage.sv
// K-input LUT stage feeding the fabric flip-flop of a fle.
// The truth table is held in a serial configuration shift chain.
// A small FSM tracks whether the last load delivered exactly 2**K bits.
// The LUT result is gated low until a good load has completed.
module fle_lut_cfg_stage #(
  parameter int K = 4
) (
  input logic               lut_clk,
  input logic               lut_reset,
  fle_lut_cfg_stage_if.slave bus
);

  localparam int N  = 2 ** K;
  localparam int CW = $clog2(N + 2);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N + 1);

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    CFGD  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          err;
  logic          err_next;
  logic [N-1:0]  sram;

  // Configuration chain: shift one bit in from ccff_head whenever cfg_en is high.
  // This happens regardless of FSM state, so over-length bits simply fall off the tail.
  always_ff @(posedge lut_clk or posedge lut_reset) begin
    if (lut_reset) begin
      sram <= '0;
    end else if (bus.cfg_en) begin
      sram <= {sram[N-2:0], bus.ccff_head};
    end
  end

  // State, load counter and sticky error flag registers.
  always_ff @(posedge lut_clk or posedge lut_reset) begin
    if (lut_reset) begin
      state <= UNCFG;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      err   <= err_next;
    end
  end

  // Next-state logic: a load starts on the first cfg_en cycle and is judged when cfg_en drops.
  // The counter saturates one past full so any over-length load is still seen as wrong.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = err;
    unique case (state)
      UNCFG, CFGD: begin
        if (bus.cfg_en) begin
          state_next = LOAD;
          cnt_next   = CNT_ONE;
          err_next   = 1'b0;
        end
      end
      LOAD: begin
        if (bus.cfg_en) begin
          if (cnt != CNT_MAX) begin
            cnt_next = cnt + CNT_ONE;
          end
        end else if (cnt == CNT_FULL) begin
          state_next = CFGD;
          err_next   = 1'b0;
        end else begin
          state_next = UNCFG;
          err_next   = 1'b1;
        end
      end
      default: begin
        state_next = UNCFG;
      end
    endcase
  end

  assign bus.ccff_tail = sram[N-1];
  assign bus.cfg_done  = (state == CFGD);
  assign bus.cfg_err   = err;
  assign bus.lut_out   = (state == CFGD) ? sram[bus.lut_in] : 1'b0;

endmodule
